// File: rtl/load_store_unit.sv
// Load/store access unit between the memory stage and a word-addressed data memory.
// Handles B/H/W loads with extension, SW directly, and SB/SH as read-modify-write.
module load_store_unit #(
    parameter int MEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // ACCESS | memory read (load, SB/SH) or direct write (SW)
    // WRITE  | write back merged word for SB/SH
    // RESP   | one-cycle response pulse
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0]  F3_B  = 3'b000;
    localparam logic [2:0]  F3_H  = 3'b001;
    localparam logic [2:0]  F3_W  = 3'b010;
    localparam logic [2:0]  F3_BU = 3'b100;
    localparam logic [2:0]  F3_HU = 3'b101;
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) * 33'd4;

    state_t      state, state_next;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;

    logic        accept;
    logic        req_err;
    logic        is_sw;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged_next;

    assign accept = (state == IDLE) && req_valid;
    assign is_sw  = r_write && (r_funct3 == F3_W);

    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            F3_B:         req_err = 1'b0;
            F3_H:         req_err = req_addr[0];
            F3_W:         req_err = (req_addr[1:0] != 2'b00);
            F3_BU:        req_err = req_write;
            F3_HU:        req_err = req_write || req_addr[0];
            default:      req_err = 1'b1;
        endcase
        if ({1'b0, req_addr} >= ADDR_LIMIT)
            req_err = 1'b1;
    end

    always_comb begin
        byte_lane = mem_dout[7:0];
        case (r_addr[1:0])
            2'd0: byte_lane = mem_dout[7:0];
            2'd1: byte_lane = mem_dout[15:8];
            2'd2: byte_lane = mem_dout[23:16];
            2'd3: byte_lane = mem_dout[31:24];
            default: byte_lane = mem_dout[7:0];
        endcase
        half_lane = r_addr[1] ? mem_dout[31:16] : mem_dout[15:0];

        load_ext = mem_dout;
        case (r_funct3)
            F3_B:    load_ext = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_ext = {24'd0, byte_lane};
            F3_H:    load_ext = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_ext = {16'd0, half_lane};
            default: load_ext = mem_dout;
        endcase
    end

    // Replace only the addressed lane of the word currently in memory.
    always_comb begin
        merged_next = mem_dout;
        if (r_funct3 == F3_B) begin
            case (r_addr[1:0])
                2'd0: merged_next[7:0]   = r_wdata[7:0];
                2'd1: merged_next[15:8]  = r_wdata[7:0];
                2'd2: merged_next[23:16] = r_wdata[7:0];
                2'd3: merged_next[31:24] = r_wdata[7:0];
                default: merged_next = mem_dout;
            endcase
        end else if (r_addr[1]) begin
            merged_next[31:16] = r_wdata[15:0];
        end else begin
            merged_next[15:0] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'd0;
        mem_din    = 32'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_addr = {r_addr[31:2], 2'b00};
                if (is_sw) begin
                    mem_write  = 1'b1;
                    mem_din    = r_wdata;
                    state_next = RESP;
                end else begin
                    mem_read   = 1'b1;
                    state_next = r_write ? WRITE : RESP;
                end
            end
            WRITE: begin
                mem_addr   = {r_addr[31:2], 2'b00};
                mem_write  = 1'b1;
                mem_din    = r_merged;
                state_next = RESP;
            end
            RESP: begin
                mem_addr   = {r_addr[31:2], 2'b00};
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A reset cycle abandons the request: no memory write, no response.
        if (reset) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            resp_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_merged   <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                r_write    <= req_write;
                r_funct3   <= req_funct3;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                resp_rdata <= 32'd0;
                resp_err   <= req_err;
            end
            if (state == ACCESS) begin
                if (!r_write)
                    resp_rdata <= load_ext;
                else
                    r_merged <= merged_next;
            end
        end
    end

endmodule
